weight_bus_ctrl: RTL and testbench

AXI4-Lite slave that owns the host side of the coupling-weight bus into the N×N coupled-cell array. It decodes host addresses into a one-hot cell select plus a direction bit. It issues single-cycle write strobes carrying the weight to the selected cell. It reads a cell's stored weight back by selecting that cell and direction and returning the cell's `rdata`. It sits between the host AXI-Lite interconnect and the array's per-cell `wready` / `wr_addr_match` / `vh` / `wdata` / `rdata` pins.

---
 rtl/weight_bus_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_weight_bus_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_bus_ctrl.sv
// AXI4-Lite slave owning the host side of the coupled-cell weight bus: address
// decode to one-hot cell select + direction, single-cycle write strobes, readback.
module weight_bus_ctrl #(
   parameter int N           = 4,
   parameter int NUM_WEIGHTS = 15,
   parameter int IDX_W       = $clog2(N)
) (
   input  logic                clk,
   input  logic                axi_rst,
   input  logic [31:0]         s_awaddr,
   input  logic                s_awvalid,
   output logic                s_awready,
   input  logic [31:0]         s_wdata,
   input  logic [3:0]          s_wstrb,
   input  logic                s_wvalid,
   output logic                s_wready,
   output logic [1:0]          s_bresp,
   output logic                s_bvalid,
   input  logic                s_bready,
   input  logic [31:0]         s_araddr,
   input  logic                s_arvalid,
   output logic                s_arready,
   output logic [31:0]         s_rdata,
   output logic [1:0]          s_rresp,
   output logic                s_rvalid,
   input  logic                s_rready,
   output logic                cell_wready,
   output logic [N*N-1:0]      cell_sel,
   output logic                cell_vh,
   output logic [31:0]         cell_wdata,
   input  logic [N*N*32-1:0]   cell_rdata
);
   localparam int W        = $clog2(NUM_WEIGHTS);
   localparam int CELLS    = N*N;
   localparam int SIDX_W   = $clog2(CELLS);
   localparam int ADDR_TOP = 3 + 2*IDX_W;

   typedef enum logic [2:0] {
      S_IDLE, S_WR_ACC, S_WR_STB, S_WR_RSP, S_RD_SEL, S_RD_RSP
   } state_t;

   typedef struct packed {
      logic              ok;
      logic              vh;
      logic [SIDX_W-1:0] idx;
   } dec_t;

   function automatic dec_t decode(input logic [31:0] a);
      dec_t d;
      int   row;
      int   col;
      row   = int'(a[3+IDX_W +: IDX_W]);
      col   = int'(a[3 +: IDX_W]);
      d.vh  = a[2];
      d.ok  = (row < N) && (col < N) && (a[31:ADDR_TOP] == '0);
      d.idx = SIDX_W'(row*N + col);
      return d;
   endfunction

   state_t         r_state, w_next;
   logic [31:0]    r_awaddr, r_araddr;
   logic [W-1:0]   r_wdata, r_rdata;
   logic           r_wstrb0, r_aw_got, r_w_got;
   logic [1:0]     r_bresp, r_rresp;

   logic           w_aw_hs, w_w_hs, w_ar_hs;
   dec_t           w_wr_dec, w_rd_dec;
   logic           w_wr_err, w_wr_stb;
   logic [CELLS-1:0] w_wr_onehot, w_rd_onehot;
   logic [W-1:0]   w_rd_slot;
   logic           w_unused;

   assign w_aw_hs     = s_awvalid & s_awready;
   assign w_w_hs      = s_wvalid & s_wready;
   assign w_ar_hs     = s_arvalid & s_arready;
   assign w_wr_dec    = decode(r_awaddr);
   assign w_rd_dec    = decode(r_araddr);
   assign w_wr_err    = ~w_wr_dec.ok | (int'(r_wdata) >= NUM_WEIGHTS);
   assign w_wr_stb    = ~w_wr_err & r_wstrb0;
   assign w_wr_onehot = CELLS'(1) << w_wr_dec.idx;
   assign w_rd_onehot = CELLS'(1) << w_rd_dec.idx;
   assign w_rd_slot   = cell_rdata[32*int'(w_rd_dec.idx) +: W];
   assign w_unused    = ^{s_wdata[31:W], s_wstrb[3:1], r_awaddr[1:0], r_araddr[1:0]};

   assign s_bresp = r_bresp;
   assign s_rresp = r_rresp;
   assign s_rdata = {{(32-W){1'b0}}, r_rdata};

   always_ff @(posedge clk) begin
      if (axi_rst) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_aw_hs & w_w_hs)      w_next = S_WR_STB;
            else if (w_aw_hs | w_w_hs) w_next = S_WR_ACC;
            else if (w_ar_hs)          w_next = S_RD_SEL;
         end
         S_WR_ACC: if ((r_aw_got | w_aw_hs) & (r_w_got | w_w_hs)) w_next = S_WR_STB;
         S_WR_STB: w_next = S_WR_RSP;
         S_WR_RSP: if (s_bvalid & s_bready) w_next = S_IDLE;
         S_RD_SEL: w_next = S_RD_RSP;
         S_RD_RSP: if (s_rvalid & s_rready) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Readies are held low during reset so nothing is accepted on the reset edge.
   always_comb begin
      s_awready   = 1'b0;
      s_wready    = 1'b0;
      s_arready   = 1'b0;
      s_bvalid    = 1'b0;
      s_rvalid    = 1'b0;
      cell_wready = 1'b0;
      cell_sel    = '0;
      cell_vh     = 1'b0;
      cell_wdata  = '0;
      case (r_state)
         S_IDLE: begin
            s_awready = ~axi_rst;
            s_wready  = ~axi_rst;
            s_arready = ~axi_rst & ~s_awvalid & ~s_wvalid;
         end
         S_WR_ACC: begin
            s_awready = ~axi_rst & ~r_aw_got;
            s_wready  = ~axi_rst & ~r_w_got;
         end
         S_WR_STB: begin
            if (w_wr_stb & ~axi_rst) begin
               cell_wready = 1'b1;
               cell_sel    = w_wr_onehot;
               cell_vh     = w_wr_dec.vh;
               cell_wdata  = {{(32-W){1'b0}}, r_wdata};
            end
         end
         S_WR_RSP: s_bvalid = 1'b1;
         S_RD_SEL: begin
            cell_vh = w_rd_dec.vh;
            if (w_rd_dec.ok) cell_sel = w_rd_onehot;
         end
         S_RD_RSP: s_rvalid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (axi_rst) begin
         r_awaddr <= '0;
         r_araddr <= '0;
         r_wdata  <= '0;
         r_wstrb0 <= 1'b0;
         r_aw_got <= 1'b0;
         r_w_got  <= 1'b0;
         r_bresp  <= 2'b00;
         r_rdata  <= '0;
         r_rresp  <= 2'b00;
      end else begin
         if (w_aw_hs) begin
            r_awaddr <= s_awaddr;
            r_aw_got <= 1'b1;
         end
         if (w_w_hs) begin
            r_wdata  <= s_wdata[W-1:0];
            r_wstrb0 <= s_wstrb[0];
            r_w_got  <= 1'b1;
         end
         if (r_state == S_WR_STB) begin
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_bresp  <= w_wr_err ? 2'b10 : 2'b00;
         end
         if (w_ar_hs) r_araddr <= s_araddr;
         if (r_state == S_RD_SEL) begin
            r_rdata <= w_rd_dec.ok ? w_rd_slot : '0;
            r_rresp <= w_rd_dec.ok ? 2'b00 : 2'b10;
         end
      end
   end

endmodule

// File: tb/tb_weight_bus_ctrl.sv
// Scoreboard bench for weight_bus_ctrl: directed scenarios plus randomized
// reads/writes against an array-level reference of the stored weights.
module tb_weight_bus_ctrl;
   localparam int N = 4, NW = 15, CELLS = 16;

   logic clk = 1'b0;
   logic axi_rst = 1'b1;
   logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
   logic [3:0]  s_wstrb = '0;
   logic s_awvalid = 0, s_wvalid = 0, s_arvalid = 0, s_bready = 1, s_rready = 1;
   logic s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
   logic [1:0]  s_bresp, s_rresp;
   logic [31:0] s_rdata, cell_wdata;
   logic cell_wready, cell_vh;
   logic [CELLS-1:0] cell_sel;
   logic [CELLS*32-1:0] cell_rdata;

   weight_bus_ctrl #(.N(N), .NUM_WEIGHTS(NW)) dut (
      .clk(clk), .axi_rst(axi_rst),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .cell_wready(cell_wready), .cell_sel(cell_sel), .cell_vh(cell_vh),
      .cell_wdata(cell_wdata), .cell_rdata(cell_rdata));

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int b_done = 0, r_done = 0;
   bit rand_rdy = 0;

   logic [1:0]  exp_b[$];
   logic [33:0] exp_r[$];
   logic [48:0] exp_s[$];
   logic [3:0]  ref_w[2][CELLS];
   logic [3:0]  cell_w[2][CELLS];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s: timed out", name);
   endtask

   // Array model: each cell keeps an hv and a vh weight, rdata follows the global vh select.
   initial for (int k = 0; k < CELLS; k++) begin
      cell_w[0][k] = '0; cell_w[1][k] = '0; ref_w[0][k] = '0; ref_w[1][k] = '0;
   end
   always @(posedge clk)
      if (cell_wready)
         for (int k = 0; k < CELLS; k++)
            if (cell_sel[k]) cell_w[cell_vh][k] <= cell_wdata[3:0];
   always_comb begin
      cell_rdata = '0;
      for (int k = 0; k < CELLS; k++) cell_rdata[32*k +: 32] = {28'hA5C3E17, cell_w[cell_vh][k]};
   end

   function automatic void ref_dec(input logic [31:0] a, output bit ok, output int vh, output int idx);
      int row, col;
      vh  = int'((a >> 2) & 1);
      col = int'((a >> 3) & 3);
      row = int'((a >> 5) & 3);
      ok  = ((a >> 7) == 0) && row < N && col < N;
      idx = row * N + col;
   endfunction

   task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb,
                               output bit stb, output logic [15:0] sel);
      bit ok; int vh, idx; bit bad;
      ref_dec(a, ok, vh, idx);
      bad = !ok || (d & 15) >= NW;
      exp_b.push_back(bad ? 2'b10 : 2'b00);
      stb = !bad && strb[0];
      sel = stb ? 16'(1 << idx) : 16'h0;
      if (stb) begin
         ref_w[vh][idx] = d[3:0];
         exp_s.push_back({sel, 1'(vh), 32'(d & 15)});
      end
   endtask

   task automatic expect_read(input logic [31:0] a, output logic [15:0] sel, output bit vh);
      bit ok; int v, idx;
      ref_dec(a, ok, v, idx);
      vh  = 1'(v);
      sel = ok ? 16'(1 << idx) : 16'h0;
      exp_r.push_back({ok ? 2'b00 : 2'b10, ok ? 32'(ref_w[v][idx]) : 32'h0});
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a strobe or a response.
   always @(negedge clk) begin
      logic [48:0] es; logic [33:0] er;
      if (!axi_rst) begin
         if (cell_sel != '0) chk("sel_onehot", 64'($countones(cell_sel)), 1);
         if (cell_wready) begin
            if (exp_s.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_strobe: sel=%h wdata=%h", cell_sel, cell_wdata);
            end else begin
               es = exp_s.pop_front();
               chk("strobe", {cell_sel, cell_vh, cell_wdata}, es);
            end
         end
         if (s_bvalid && s_bready) begin
            if (exp_b.size() == 0) begin
               checks++; failures++; $display("FAIL unexpected_b: bresp=%0d", s_bresp);
            end else chk("bresp", s_bresp, exp_b.pop_front());
            b_done++;
         end
         if (s_rvalid && s_rready) begin
            if (exp_r.size() == 0) begin
               checks++; failures++; $display("FAIL unexpected_r: rdata=%h", s_rdata);
            end else begin
               er = exp_r.pop_front();
               chk("rresp_rdata", {s_rresp, s_rdata}, er);
            end
            r_done++;
         end
      end
   end

   always @(posedge clk)
      if (rand_rdy) begin
         #1;
         s_bready = 1'($urandom_range(0, 1));
         s_rready = 1'($urandom_range(0, 1));
      end

   task automatic wait_ready(input int ch, input string name);
      int n = 0; bit got;
      do begin
         @(negedge clk);
         got = (ch == 0) ? s_awready : (ch == 1) ? s_wready : s_arready;
         @(posedge clk);
         n++;
      end while (!got && n < 64);
      if (!got) timeout(name);
      #1;
   endtask

   task automatic drive_aw(input logic [31:0] a, input int dly);
      repeat (dly) @(posedge clk);
      #1; s_awaddr = a; s_awvalid = 1;
      wait_ready(0, "aw_hs");
      s_awvalid = 0;
   endtask

   task automatic drive_w(input logic [31:0] d, input logic [3:0] strb, input int dly);
      repeat (dly) @(posedge clk);
      #1; s_wdata = d; s_wstrb = strb; s_wvalid = 1;
      wait_ready(1, "w_hs");
      s_wvalid = 0;
   endtask

   task automatic drive_ar(input logic [31:0] a);
      #1; s_araddr = a; s_arvalid = 1;
      wait_ready(2, "ar_hs");
      s_arvalid = 0;
   endtask

   task automatic wait_b(input int nb);
      int n = 0;
      while (b_done == nb && n < 200) begin @(posedge clk); n++; end
      #1;
      if (b_done == nb) timeout("b_wait");
   endtask

   task automatic wait_r(input int nr);
      int n = 0;
      while (r_done == nr && n < 200) begin @(posedge clk); n++; end
      #1;
      if (r_done == nr) timeout("r_wait");
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb,
                           input int da, input int dw);
      bit stb; logic [15:0] sel; int nb;
      expect_write(a, d, strb, stb, sel);
      nb = b_done;
      fork
         drive_aw(a, da);
         drive_w(d, strb, dw);
      join
      @(negedge clk);
      chk("stb_lat", cell_wready, stb);
      chk("stb_sel", cell_sel, sel);
      @(negedge clk);
      chk("b_lat", s_bvalid, 1);
      wait_b(nb);
   endtask

   task automatic do_read(input logic [31:0] a);
      logic [15:0] sel; bit vh; int nr;
      expect_read(a, sel, vh);
      nr = r_done;
      drive_ar(a);
      @(negedge clk);
      chk("rd_sel", cell_sel, sel);
      chk("rd_vh", cell_vh, vh);
      chk("rd_nostb", cell_wready, 0);
      @(negedge clk);
      chk("r_lat", s_rvalid, 1);
      wait_r(nr);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit stb; logic [15:0] sel; bit vh; int nb, nr, n;
      logic [31:0] a;

      // Reset state
      @(posedge clk); @(negedge clk);
      chk("rst_awready", s_awready, 0);
      chk("rst_wready", s_wready, 0);
      chk("rst_arready", s_arready, 0);
      @(posedge clk); #1 axi_rst = 0;
      @(negedge clk);
      chk("idle_awready", s_awready, 1);
      chk("idle_wready", s_wready, 1);
      chk("idle_arready", s_arready, 1);
      chk("rst_outs", {s_bvalid, s_rvalid, cell_wready, cell_vh, s_bresp, s_rresp}, 0);
      chk("rst_sel", cell_sel, 0);
      chk("rst_data", {s_rdata, cell_wdata}, 0);

      // Basic write/read of cell 6 vh, opposite direction, and error cases
      @(posedge clk);
      do_write(32'h34, 32'hB, 4'hF, 0, 0);
      do_read(32'h34);
      do_read(32'h30);
      do_write(32'h80, 32'h5, 4'hF, 0, 0);
      do_write(32'h34, 32'hF, 4'hF, 0, 0);
      do_write(32'h34, 32'h3, 4'hE, 0, 0);
      do_read(32'h34);
      do_read(32'h80);

      // AW first, W three cycles later
      expect_write(32'h28, 32'h7, 4'h1, stb, sel);
      nb = b_done;
      #1 s_awaddr = 32'h28; s_awvalid = 1;
      @(negedge clk); chk("aw0_ready", s_awready, 1);
      @(posedge clk); #1 s_awvalid = 0;
      @(negedge clk); chk("acc_awready1", s_awready, 0); chk("acc_wready", s_wready, 1);
      @(posedge clk);
      @(negedge clk); chk("acc_awready2", s_awready, 0);
      @(posedge clk); #1 s_wdata = 32'h7; s_wstrb = 4'h1; s_wvalid = 1;
      @(negedge clk); chk("acc_awready3", s_awready, 0);
      @(posedge clk); #1 s_wvalid = 0;
      @(negedge clk); chk("acc_stb", cell_wready, 1);
      @(negedge clk); chk("acc_bvalid", s_bvalid, 1);
      wait_b(nb);
      do_read(32'h28);

      // Simultaneous AW, W and AR: write wins, AR follows the B handshake
      expect_write(32'h3C, 32'h9, 4'h1, stb, sel);
      expect_read(32'h3C, sel, vh);
      nb = b_done; nr = r_done;
      #1 s_awaddr = 32'h3C; s_wdata = 32'h9; s_wstrb = 4'h1; s_araddr = 32'h3C;
      s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
      @(negedge clk); chk("prio_arready_idle", s_arready, 0);
      @(posedge clk); #1 s_awvalid = 0; s_wvalid = 0;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         chk("prio_arready_busy", s_arready, 0);
         n++;
         if (s_bvalid && s_bready) begin @(posedge clk); break; end
      end
      @(negedge clk); chk("prio_arready_after_b", s_arready, 1);
      @(posedge clk); #1 s_arvalid = 0;
      wait_b(nb);
      wait_r(nr);

      // Stalled B response then reset drops it
      s_bready = 0;
      expect_write(32'h80, 32'h1, 4'h1, stb, sel);
      fork
         drive_aw(32'h80, 0);
         drive_w(32'h1, 4'h1, 0);
      join
      @(negedge clk);
      repeat (5) begin
         @(negedge clk);
         chk("hold_bvalid", s_bvalid, 1);
         chk("hold_bresp", s_bresp, 2'b10);
      end
      @(posedge clk); #1 axi_rst = 1;
      @(posedge clk); #1 axi_rst = 0;
      @(negedge clk);
      chk("rst_drop_bvalid", s_bvalid, 0);
      chk("rst_idle_awready", s_awready, 1);
      exp_b.delete();
      @(posedge clk); #1 s_bready = 1;
      do_read(32'h34);

      // Randomized traffic
      rand_rdy = 1;
      for (int i = 0; i < 60; i++) begin
         a = {25'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 7) == 0) a[$urandom_range(7, 31)] = 1'b1;
         if ($urandom_range(0, 1) == 1)
            do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            do_read(a);
      end
      rand_rdy = 0;
      @(posedge clk); #2 s_bready = 1; s_rready = 1;
      for (int k = 0; k < CELLS; k++) begin
         do_read(32'(k << 3) | 32'h4);
         do_read(32'(k << 3));
      end
      repeat (3) @(posedge clk);
      chk("scoreboard_b_empty", 64'(exp_b.size()), 0);
      chk("scoreboard_r_empty", 64'(exp_r.size()), 0);
      chk("scoreboard_s_empty", 64'(exp_s.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
